// File: rtl/matrix_mul_seq_if.sv
// Producer/consumer handshake bundle for matrix_mul_seq: input vector side and
// result side, each with its own valid/ready pair.
interface matrix_mul_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] di0;
  logic [3:0] di1;
  logic [3:0] di2;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] mo0;
  logic [9:0] mo1;
  logic [9:0] mo2;
  logic       busy;

  modport master (
    output in_valid, di0, di1, di2, out_ready,
    input  in_ready, out_valid, mo0, mo1, mo2, busy
  );

  modport slave (
    input  in_valid, di0, di1, di2, out_ready,
    output in_ready, out_valid, mo0, mo1, mo2, busy
  );
endinterface

// File: rtl/matrix_mul_seq.sv
// Constant 3x3 matrix times 3-vector, one shared multiply-accumulate stepped
// through the nine products (row-major), one product per clock.
module matrix_mul_seq #(
  parameter int unsigned A = 7,
  parameter int unsigned B = 13,
  parameter int unsigned C = 5
) (
  input  logic             clk,
  input  logic             rst,
  matrix_mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [3:0] CA = 4'(A);
  localparam logic [3:0] CB = 4'(B);
  localparam logic [3:0] CC = 4'(C);

  state_e          state_q, state_d;
  logic [3:0]      step_q, step_d;
  logic [9:0]      acc_q, acc_d;
  logic [2:0][3:0] vec_q, vec_d;
  logic [2:0][9:0] mo_q, mo_d;
  logic            out_valid_q, out_valid_d;

  logic [1:0] row, col;
  logic [3:0] coef;
  logic [7:0] prod;
  logic [9:0] sum;

  // Rows of the matrix: [A B C], [B B A], [C B A].
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    {row, col, coef} = {2'd0, 2'd0, CA};
    case (step_q)
      4'd0:    {row, col, coef} = {2'd0, 2'd0, CA};
      4'd1:    {row, col, coef} = {2'd0, 2'd1, CB};
      4'd2:    {row, col, coef} = {2'd0, 2'd2, CC};
      4'd3:    {row, col, coef} = {2'd1, 2'd0, CB};
      4'd4:    {row, col, coef} = {2'd1, 2'd1, CB};
      4'd5:    {row, col, coef} = {2'd1, 2'd2, CA};
      4'd6:    {row, col, coef} = {2'd2, 2'd0, CC};
      4'd7:    {row, col, coef} = {2'd2, 2'd1, CB};
      4'd8:    {row, col, coef} = {2'd2, 2'd2, CA};
      default: {row, col, coef} = {2'd0, 2'd0, CA};
    endcase
  end

  assign prod = {4'b0, coef} * {4'b0, vec_q[col]};
  assign sum  = acc_q + {2'b0, prod};

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    vec_d       = vec_q;
    mo_d        = mo_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          vec_d   = {bus.di2, bus.di1, bus.di0};
          step_d  = 4'd0;
          acc_d   = 10'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (col == 2'd2) begin
          mo_d[row] = sum;
          acc_d     = 10'd0;
        end else begin
          acc_d = sum;
        end
        if (step_q == 4'd8) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the captured vector and result registers are reset too, so mo reads 0 after any reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 4'd0;
      acc_q       <= 10'd0;
      vec_q       <= '0;
      mo_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      vec_q       <= vec_d;
      mo_q        <= mo_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.mo0       = mo_q[0];
  assign bus.mo1       = mo_q[1];
  assign bus.mo2       = mo_q[2];

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Self-checking bench for matrix_mul_seq: constant vector table, hand-written
// corner sequences and random back-to-back vectors against a matrix model.
module tb_matrix_mul_seq;

  localparam int CA = 7;
  localparam int CB = 13;
  localparam int CC = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  matrix_mul_seq_if bus ();

  matrix_mul_seq #(.A(CA), .B(CB), .C(CC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d0, d1, d2;
    int         e0, e1, e2;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Plain matrix-vector product with the fixed coefficient matrix.
  function automatic int model(input int row, input int v0, input int v1, input int v2);
    int m [3][3];
    int v [3];
    int s;
    m = '{'{CA, CB, CC}, '{CB, CB, CA}, '{CC, CB, CA}};
    v = '{v0, v1, v2};
    s = 0;
    for (int k = 0; k < 3; k++) s += m[row][k] * v[k];
    return s;
  endfunction

  task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    int n = 0;
    bus.di0 = a; bus.di1 = b; bus.di2 = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    check("accept_wait", int'(n < 50), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.di0 = 'x; bus.di1 = 'x; bus.di2 = 'x;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic check_mo(input string name, input int e0, input int e1, input int e2);
    check({name, "_mo0"}, int'(bus.mo0), e0);
    check({name, "_mo1"}, int'(bus.mo1), e1);
    check({name, "_mo2"}, int'(bus.mo2), e2);
  endtask

  vec_t tbl [6];

  initial begin
    int lat, n, last_acc, busy_cnt;
    int s0, s1, s2;
    logic [3:0] cur0, cur1, cur2, nx0, nx1, nx2;

    tbl[0] = '{4'd1,  4'd2,  4'd3,  48,  60,  52};
    tbl[1] = '{4'd1,  4'd0,  4'd0,  7,   13,  5};
    tbl[2] = '{4'd0,  4'd1,  4'd0,  13,  13,  13};
    tbl[3] = '{4'd0,  4'd0,  4'd1,  5,   7,   7};
    tbl[4] = '{4'd15, 4'd15, 4'd15, 375, 495, 375};
    tbl[5] = '{4'd0,  4'd0,  4'd0,  0,   0,   0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.di0 = '0; bus.di1 = '0; bus.di2 = '0;
    tick(); tick();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check_mo("rst", 0, 0, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", int'(bus.in_ready), 1);

    // Table of vectors with fixed expected results, one full handshake each.
    for (int i = 0; i < 6; i++) begin
      accept(tbl[i].d0, tbl[i].d1, tbl[i].d2);
      check("tbl_busy", int'(bus.busy), 1);
      wait_done(lat);
      check("tbl_latency", lat, 9);
      check_mo("tbl", tbl[i].e0, tbl[i].e1, tbl[i].e2);
      bus.out_ready = 1'b1;
      check("tbl_no_bypass", int'(bus.in_ready), 0);
      tick();
      bus.out_ready = 1'b0;
      check("tbl_ov_clear", int'(bus.out_valid), 0);
      check("tbl_in_ready", int'(bus.in_ready), 1);
      check_mo("tbl_hold", tbl[i].e0, tbl[i].e1, tbl[i].e2);
    end

    // Stall in DONE with in_valid pulses that must be ignored.
    accept(4'd2, 4'd5, 4'd9);
    wait_done(lat);
    check("stall_latency", lat, 9);
    s0 = model(0, 2, 5, 9); s1 = model(1, 2, 5, 9); s2 = model(2, 2, 5, 9);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0] ? 1'b0 : 1'b1;
      bus.di0 = 4'd9; bus.di1 = 4'd9; bus.di2 = 4'd9;
      tick();
      check("stall_out_valid", int'(bus.out_valid), 1);
      check("stall_in_ready", int'(bus.in_ready), 0);
      check_mo("stall", s0, s1, s2);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    check("stall_idle_busy", int'(bus.busy), 0);
    check_mo("stall_after", s0, s1, s2);

    // Nonzero result then an all-zero vector: busy for exactly 10 cycles.
    bus.out_ready = 1'b1;
    accept(4'd11, 4'd3, 4'd6);
    wait_done(lat);
    check_mo("pre_zero", model(0, 11, 3, 6), model(1, 11, 3, 6), model(2, 11, 3, 6));
    accept(4'd0, 4'd0, 4'd0);
    busy_cnt = 0;
    while (bus.busy && busy_cnt < 30) begin busy_cnt++; tick(); end
    check("zero_busy_cycles", busy_cnt, 10);
    check_mo("zero", 0, 0, 0);
    bus.out_ready = 1'b0;

    // Reset in the middle of a calculation (step 4, row 0 already written).
    accept(4'd3, 4'd4, 4'd5);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check_mo("midrst", 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    check("postrst_in_ready", int'(bus.in_ready), 1);
    check("postrst_busy", int'(bus.busy), 0);
    check("postrst_out_valid", int'(bus.out_valid), 0);
    check_mo("postrst", 0, 0, 0);

    // Back-to-back random vectors, in_valid and out_ready held high.
    bus.out_ready = 1'b1;
    cur0 = 4'($urandom_range(0, 15)); cur1 = 4'($urandom_range(0, 15)); cur2 = 4'($urandom_range(0, 15));
    bus.di0 = cur0; bus.di1 = cur1; bus.di2 = cur2;
    bus.in_valid = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 100; i++) begin
      n = 0;
      while (!bus.in_ready && n < 50) begin tick(); n++; end
      check("b2b_ready_wait", int'(n < 50), 1);
      tick();
      if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 11);
      last_acc = cyc;
      nx0 = 4'($urandom_range(0, 15)); nx1 = 4'($urandom_range(0, 15)); nx2 = 4'($urandom_range(0, 15));
      bus.di0 = nx0; bus.di1 = nx1; bus.di2 = nx2;
      wait_done(lat);
      check("b2b_latency", lat, 9);
      check_mo("b2b", model(0, cur0, cur1, cur2), model(1, cur0, cur1, cur2), model(2, cur0, cur1, cur2));
      cur0 = nx0; cur1 = nx1; cur2 = nx2;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
